// File: rtl/led_heartbeat.sv
// ---------------------------------------------------------------------------
// led_heartbeat
//
// Multi-channel LED indicator generator. Each of NUM_CH channels is
// independently off, on, blinking at a programmable half-period, or
// "breathing" (PWM ramp). A shared prescaler provides the tick time base;
// a sync pulse realigns the prescaler and every channel phase.
//
// Optional feature macro: LED_PWM_EN
//   defined   -> mode 11 is breathe (PWM ramp)
//   undefined -> no PWM/duty/direction/previous-mode logic; mode 11 = blink
//
// Parameters:
//   NUM_CH      number of LED channels (1..8)
//   TICK_DIV    sys_clk cycles per tick (>= 2)
//   PER_W       width of each channel's half-period field (ticks)
//
// Ports:
//   sys_clk      system clock
//   sys_rst      synchronous active-high reset
//   mode         2 bits per channel: 00 off, 01 on, 10 blink, 11 breathe
//   half_period  PER_W bits per channel, blink half-period in ticks (0 -> 1)
//   sync         one-cycle pulse restarting prescaler and all phases
//   led_o        registered LED drive, 1 = lit
//   tick_o       one-cycle strobe when the prescaler wraps
// ---------------------------------------------------------------------------
module led_heartbeat #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 100000,
    parameter int PER_W    = 12
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [PER_W*NUM_CH-1:0]   half_period,
    input  logic                      sync,
    output logic [NUM_CH-1:0]         led_o,
    output logic                      tick_o
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    localparam logic [PER_W-1:0] PER_ZERO = {PER_W{1'b0}};
    localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

    // Prescaler
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             tick_s;

    // Blink engine
    logic [PER_W-1:0] cnt_q   [NUM_CH];
    logic [PER_W-1:0] cnt_d   [NUM_CH];
    logic [PER_W-1:0] hm1_s   [NUM_CH];
    logic [NUM_CH-1:0] state_q;
    logic [NUM_CH-1:0] state_d;

    // Output register
    logic [NUM_CH-1:0] led_q;
    logic [NUM_CH-1:0] led_d;

`ifdef LED_PWM_EN
    // Breathe engine
    logic [7:0]          pwm_q;
    logic [7:0]          pwm_d;
    logic [7:0]          duty_q [NUM_CH];
    logic [7:0]          duty_d [NUM_CH];
    logic [NUM_CH-1:0]   dir_q;
    logic [NUM_CH-1:0]   dir_d;
    logic [2*NUM_CH-1:0] mode_prev_q;
    logic [2*NUM_CH-1:0] mode_prev_d;
`endif

    // Prescaler next state; sync outranks the wrap
    always_comb begin
        tick_s = (pre_q == PRE_MAX);
        pre_d  = pre_q;
        if (sync) begin
            pre_d = {PRE_W{1'b0}};
        end else if (tick_s) begin
            pre_d = {PRE_W{1'b0}};
        end else begin
            pre_d = pre_q + PRE_ONE;
        end
    end

    assign tick_o = tick_s;

    // Blink engine next state. Comparing with >= (rather than ==) means a
    // half-period lowered below the current count toggles on the next tick
    // instead of letting the counter run all the way round.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hm1_s[i]   = PER_ZERO;
            cnt_d[i]   = cnt_q[i];
            state_d[i] = state_q[i];
            if (half_period[PER_W*i +: PER_W] == PER_ZERO) begin
                hm1_s[i] = PER_ZERO;
            end else begin
                hm1_s[i] = half_period[PER_W*i +: PER_W] - PER_ONE;
            end
            if (sync) begin
                cnt_d[i]   = PER_ZERO;
                state_d[i] = 1'b0;
            end else if (tick_s) begin
                if (cnt_q[i] >= hm1_s[i]) begin
                    cnt_d[i]   = PER_ZERO;
                    state_d[i] = ~state_q[i];
                end else begin
                    cnt_d[i]   = cnt_q[i] + PER_ONE;
                    state_d[i] = state_q[i];
                end
            end else begin
                cnt_d[i]   = cnt_q[i];
                state_d[i] = state_q[i];
            end
        end
    end

`ifdef LED_PWM_EN
    // Breathe engine next state: ramp restarts on entry into mode 11, then
    // walks duty up/down one step per tick, turning around at the ends.
    always_comb begin
        pwm_d       = sync ? 8'd0 : (pwm_q + 8'd1);
        mode_prev_d = mode;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = duty_q[i];
            dir_d[i]  = dir_q[i];
            if (sync) begin
                duty_d[i] = 8'd0;
                dir_d[i]  = 1'b1;
            end else if ((mode[2*i +: 2] == 2'b11) &&
                         (mode_prev_q[2*i +: 2] != 2'b11)) begin
                duty_d[i] = 8'd0;
                dir_d[i]  = 1'b1;
            end else if ((mode[2*i +: 2] == 2'b11) && tick_s) begin
                if (dir_q[i]) begin
                    if (duty_q[i] == 8'd255) begin
                        dir_d[i] = 1'b0;
                    end else begin
                        duty_d[i] = duty_q[i] + 8'd1;
                    end
                end else begin
                    if (duty_q[i] == 8'd0) begin
                        dir_d[i] = 1'b1;
                    end else begin
                        duty_d[i] = duty_q[i] - 8'd1;
                    end
                end
            end else begin
                duty_d[i] = duty_q[i];
                dir_d[i]  = dir_q[i];
            end
        end
    end
`endif

    // Output mux, registered so LED pins see no combinational glitches
    always_comb begin
        led_d = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode[2*i +: 2])
                2'b00:   led_d[i] = 1'b0;
                2'b01:   led_d[i] = 1'b1;
                2'b10:   led_d[i] = state_q[i];
`ifdef LED_PWM_EN
                2'b11:   led_d[i] = (pwm_q < duty_q[i]);
`else
                2'b11:   led_d[i] = state_q[i];
`endif
                default: led_d[i] = 1'b0;
            endcase
        end
    end

    // State registers for prescaler, blink engines and LED outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_q   <= {PRE_W{1'b0}};
            state_q <= {NUM_CH{1'b0}};
            led_q   <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= PER_ZERO;
            end
        end else begin
            pre_q   <= pre_d;
            state_q <= state_d;
            led_q   <= led_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef LED_PWM_EN
    // State registers for the breathe engines
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pwm_q       <= 8'd0;
            dir_q       <= {NUM_CH{1'b1}};
            mode_prev_q <= {(2*NUM_CH){1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= 8'd0;
            end
        end else begin
            pwm_q       <= pwm_d;
            dir_q       <= dir_d;
            mode_prev_q <= mode_prev_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end
`endif

    assign led_o = led_q;

endmodule

// File: tb/tb_led_heartbeat.sv
// ---------------------------------------------------------------------------
// tb_led_heartbeat
//
// Scoreboard bench for led_heartbeat with TICK_DIV=4. Expected output bits
// are queued (phase, cycle, selector, value) as stimulus is applied, and a
// negedge monitor pops and compares each entry when its cycle arrives.
// Cycle 0 is the first cycle after reset release.
// ---------------------------------------------------------------------------
module tb_led_heartbeat;

    localparam int NUM_CH   = 4;
    localparam int TICK_DIV = 4;
    localparam int PER_W    = 12;

    logic                      sys_clk = 1'b0;
    logic                      sys_rst;
    logic [2*NUM_CH-1:0]       mode;
    logic [PER_W*NUM_CH-1:0]   half_period;
    logic                      sync;
    logic [NUM_CH-1:0]         led_o;
    logic                      tick_o;

    led_heartbeat #(
        .NUM_CH   (NUM_CH),
        .TICK_DIV (TICK_DIV),
        .PER_W    (PER_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .mode        (mode),
        .half_period (half_period),
        .sync        (sync),
        .led_o       (led_o),
        .tick_o      (tick_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         ph;
        int         cyc;
        int         sel;   // 0..3 led bit, 4 tick_o, 5 whole led_o
        logic [3:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        cyc;
    int        phase;
    int        n_checks;
    int        n_pass;

    // cycle counter: 0 in the first cycle after reset release
    always @(posedge sys_clk) begin
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input int sel, input logic [3:0] e);
        sb_entry_t ent;
        ent.ph  = phase;
        ent.cyc = c;
        ent.sel = sel;
        ent.exp = e;
        sb.push_back(ent);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // monitor: compare every queued expectation due in this cycle
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].ph == phase && sb[k].cyc == cyc) begin
                    logic [3:0] obs;
                    string      tag;
                    case (sb[k].sel)
                        0, 1, 2, 3: obs = {3'b000, led_o[sb[k].sel]};
                        4:          obs = {3'b000, tick_o};
                        default:    obs = led_o;
                    endcase
                    tag = $sformatf("p%0d_c%0d_sel%0d", phase, cyc, sb[k].sel);
                    check_eq(tag, {28'd0, obs}, {28'd0, sb[k].exp});
                    sb.delete(k);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        phase    = 1;
        sys_rst  = 1'b1;
        sync     = 1'b0;
        // ch3 mode 11 (H=2), ch2 blink H=10, ch1 off, ch0 blink H=3
        mode        = {2'b11, 2'b10, 2'b00, 2'b10};
        half_period = {12'd2, 12'd10, 12'd0, 12'd3};

        @(posedge sys_clk); #1;
        check_eq("rst_led", {28'd0, led_o}, 32'd0);
        check_eq("rst_tick", {31'd0, tick_o}, 32'd0);
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;

        // prescaler strobe
        push(0, 4, 4'd0);  push(2, 4, 4'd0);  push(3, 4, 4'd1);
        push(4, 4, 4'd0);  push(7, 4, 4'd1);  push(11, 4, 4'd1);
        // ch0 blink H=3: rise 13, fall 25, rise 37
        push(12, 0, 4'd0); push(13, 0, 4'd1); push(24, 0, 4'd1);
        push(25, 0, 4'd0); push(36, 0, 4'd0); push(37, 0, 4'd1);
        // ch2 blink H=10: first rise at 41
        push(40, 2, 4'd0); push(41, 2, 4'd1);
`ifdef LED_PWM_EN
        // breathe: duty still tiny early on, LED stays dark
        push(8, 3, 4'd0);  push(9, 3, 4'd0);
`else
        // mode 11 behaves as blink H=2: rise 9, fall 17
        push(8, 3, 4'd0);  push(9, 3, 4'd1);
        push(16, 3, 4'd1); push(17, 3, 4'd0);
`endif
        sys_rst = 1'b0;

        // static modes on ch1
        wait_cyc(20);
        mode[3:2] = 2'b01;
        push(20, 1, 4'd0); push(21, 1, 4'd1);
        wait_cyc(30);
        mode[3:2] = 2'b00;
        push(30, 1, 4'd1); push(31, 1, 4'd0);

        // sync coincident with the tick at cycle 43
        wait_cyc(43);
        sync = 1'b1;
        push(44, 0, 4'd1); push(45, 0, 4'd0);
        push(56, 0, 4'd0); push(57, 0, 4'd1);
        push(44, 2, 4'd1); push(45, 2, 4'd0);
        push(44, 4, 4'd0); push(46, 4, 4'd0); push(47, 4, 4'd1);
`ifdef LED_PWM_EN
        // pwm restarts at 44; wraps to 0 at 300 when duty is 64
        push(300, 3, 4'd0); push(301, 3, 4'd1);
`else
        push(44, 3, 4'd1); push(45, 3, 4'd0);
        push(52, 3, 4'd0); push(53, 3, 4'd1);
`endif
        wait_cyc(44);
        sync = 1'b0;

        // ch2 count is 6 after the tick at 67; shrink H to 3
        wait_cyc(68);
        half_period[24 +: 12] = 12'd3;
        push(72, 2, 4'd0); push(73, 2, 4'd1);

        // mid-operation reset, then H=0 blink on ch0
        wait_cyc(305);
        sys_rst     = 1'b1;
        phase       = 2;
        mode        = {2'b00, 2'b00, 2'b00, 2'b10};
        half_period = {PER_W*NUM_CH{1'b0}};
        @(posedge sys_clk); #1;
        check_eq("rst2_led", {28'd0, led_o}, 32'd0);
        check_eq("rst2_tick", {31'd0, tick_o}, 32'd0);
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        push(2, 4, 4'd0);  push(3, 4, 4'd1);  push(3, 5, 4'd0);
        push(4, 0, 4'd0);  push(5, 0, 4'd1);  push(8, 0, 4'd1);
        push(9, 0, 4'd0);  push(13, 0, 4'd1);
        sys_rst = 1'b0;
        wait_cyc(16);

        check_eq("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
